// File: rtl/aes_key_sequencer.sv
// AES-128 key schedule sequencer.
// Presents round keys 0..10 one at a time on a valid/ready port and computes one
// expansion round per accepted key. A single g-function instance is shared by all
// rounds, so the rounds are never unrolled.
//
// Handshake: rk_valid is high for the whole EMIT state. rk_data and rk_round stay
// stable while rk_valid=1 and rk_ready=0. A transfer happens on a rising edge where
// rk_valid & rk_ready. abort takes priority over a transfer in the same cycle.

// g(): RotWord, SubWord, then Rcon XORed into the top byte.
// The S-box is built arithmetically: the GF(2^8) inverse (x^254), then the affine map.
module aes_key_gfunc (
  input  logic [31:0] word,
  input  logic [3:0]  round,
  output logic [31:0] g
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    // The product x^2 * x^4 * ... * x^128 equals x^254, which is the inverse (0 maps to 0).
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  logic [31:0] rot;
  logic [7:0]  rcon;

  assign rot = {word[23:0], word[31:24]};

  // Round constant for the round being generated (1..10).
  always_comb begin
    rcon = 8'h00;
    case (round)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign g = {sbox(rot[31:24]) ^ rcon, sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};

endmodule

module aes_key_sequencer (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic [127:0] key,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [3:0]   rk_round,
  output logic [127:0] rk_data,
  output logic         done
);

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] w0, w1, w2, w3;
  logic [31:0] nw0, nw1, nw2, nw3;
  logic [31:0] g_word;
  logic [3:0]  round_q;
  logic [3:0]  round_inc;
  logic        done_q;
  logic        xfer;
  logic        advance;
  logic        finish;

  // A transfer that is not overridden by abort either steps the schedule or ends it.
  assign xfer      = (state == EMIT) & rk_ready & ~abort;
  assign advance   = xfer & (round_q != 4'd10);
  assign finish    = xfer & (round_q == 4'd10);
  assign round_inc = round_q + 4'd1;

  aes_key_gfunc u_gfunc (
    .word  (w3),
    .round (round_inc),
    .g     (g_word)
  );

  assign nw0 = w0 ^ g_word;
  assign nw1 = w1 ^ nw0;
  assign nw2 = w2 ^ nw1;
  assign nw3 = w3 ^ nw2;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state: start leaves IDLE; abort or the final transfer returns to IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = EMIT;
      EMIT:    if (abort || finish) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from the state.
  always_comb begin
    rk_valid = (state == EMIT);
    busy     = (state == EMIT);
  end

  // Word registers, round index and done pulse. The key is sampled only when a start is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w0      <= '0;
      w1      <= '0;
      w2      <= '0;
      w3      <= '0;
      round_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= finish;
      if (state == IDLE && start) begin
        w0      <= key[127:96];
        w1      <= key[95:64];
        w2      <= key[63:32];
        w3      <= key[31:0];
        round_q <= 4'd0;
      end else if (advance) begin
        w0      <= nw0;
        w1      <= nw1;
        w2      <= nw2;
        w3      <= nw3;
        round_q <= round_inc;
      end
    end
  end

  assign rk_data  = {w0, w1, w2, w3};
  assign rk_round = round_q;
  assign done     = done_q;

endmodule

// File: tb/tb_aes_key_sequencer.sv
// Bench for aes_key_sequencer: a driver issues keys, and a reference key schedule
// pushes the 11 expected {round, key} pairs at acceptance. A negedge monitor pops and
// compares them on every transfer, and it also checks valid/busy/done and stall stability.
module tb_aes_key_sequencer;

  logic         clk;
  logic         rst;
  logic         start;
  logic         abort;
  logic [127:0] key;
  logic         busy;
  logic         rk_valid;
  logic         rk_ready;
  logic [3:0]   rk_round;
  logic [127:0] rk_data;
  logic         done;

  aes_key_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .key      (key),
    .busy     (busy),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk_round (rk_round),
    .rk_data  (rk_data),
    .done     (done)
  );

  int checks = 0;
  int failures = 0;

  logic [131:0] exp_q[$];
  logic [7:0]   sbox_t[256];
  logic [127:0] sched[11];
  logic [127:0] got_rk[11];
  logic [127:0] ref_rk[11];
  bit           ready_full = 1'b1;
  bit           exp_done = 1'b0;
  bit           prev_hold = 1'b0;
  logic [131:0] held;
  logic [131:0] mon_e;

  // Clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [131:0] act, input logic [131:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // S-box from the multiplicative group generator 3 (not the inverse-power construction).
  task automatic build_sbox();
    logic [7:0] p;
    logic [7:0] q;
    logic [7:0] x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  endtask

  // Standard 44-word expansion; each round key is four consecutive words.
  task automatic expand_key(input logic [127:0] k);
    logic [31:0] w[44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
        t = t ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) sched[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Consumer readiness, redrawn each cycle (also while idle).
  always @(posedge clk) begin
    #1;
    rk_ready = ready_full ? 1'b1 : ($urandom_range(0, 2) != 0);
  end

  // Monitor: one sample per cycle, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      prev_hold = 1'b0;
      exp_done  = 1'b0;
    end else begin
      check("done", {131'b0, done}, {131'b0, exp_done});
      exp_done = 1'b0;
      check("rk_valid", {131'b0, rk_valid}, {131'b0, exp_q.size() != 0});
      check("busy", {131'b0, busy}, {131'b0, exp_q.size() != 0});
      if (prev_hold) check("stall_stable", {rk_round, rk_data}, held);
      prev_hold = 1'b0;
      if (rk_valid) check("round_range", {131'b0, rk_round <= 4'd10}, 132'd1);
      if (rk_valid && exp_q.size() != 0) begin
        if (abort) begin
          exp_q.delete();
        end else if (rk_ready) begin
          mon_e = exp_q.pop_front();
          check("round_key", {rk_round, rk_data}, mon_e);
          got_rk[mon_e[131:128]] = rk_data;
          if (mon_e[131:128] == 4'd10) exp_done = 1'b1;
        end else begin
          prev_hold = 1'b1;
          held = {rk_round, rk_data};
        end
      end
    end
  end

  // Assert start (optionally with abort) from idle and queue the expected schedule.
  task automatic issue_start(input logic [127:0] k, input bit with_abort);
    key = k;
    start = 1'b1;
    abort = with_abort;
    tick();
    start = 1'b0;
    abort = 1'b0;
    expand_key(k);
    for (int r = 0; r < 11; r++) exp_q.push_back({4'(r), sched[r]});
  endtask

  // Run until the schedule drains; optionally inject start pulses/key changes, or abort at a round.
  task automatic wait_idle(input bit noise, input int abort_round);
    int n;
    bit aborted;
    n = 0;
    aborted = 1'b0;
    while (exp_q.size() != 0 && n < 400) begin
      start = 1'b0;
      abort = 1'b0;
      if (noise) begin
        key = rand128();
        if ($urandom_range(0, 2) == 0) start = 1'b1;
      end
      if (!aborted && abort_round >= 0 && rk_valid && int'(rk_round) == abort_round) begin
        abort = 1'b1;
        aborted = 1'b1;
      end
      tick();
      n++;
    end
    start = 1'b0;
    abort = 1'b0;
    check("seq_drained", {100'b0, exp_q.size()}, 132'd0);
    exp_q.delete();
  endtask

  task automatic clear_got();
    for (int r = 0; r < 11; r++) got_rk[r] = '0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"}, {131'b0, rk_valid}, 132'd0);
    check({tag, "_busy"}, {131'b0, busy}, 132'd0);
    check({tag, "_done"}, {131'b0, done}, 132'd0);
    check({tag, "_round"}, {128'b0, rk_round}, 132'd0);
    check({tag, "_data"}, {4'b0, rk_data}, 132'd0);
  endtask

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] SEQ_KEY  = 128'h000102030405060708090a0b0c0d0e0f;

  // Main stimulus.
  initial begin
    int n;
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    key = '0;
    rk_ready = 1'b1;
    build_sbox();
    #3;
    check_outputs_zero("reset");
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    repeat (3) tick();

    // Full-rate FIPS-197 vector.
    ready_full = 1'b1;
    clear_got();
    issue_start(FIPS_KEY, 1'b0);
    wait_idle(1'b0, -1);
    check("fips_round1", {4'b0, got_rk[1]}, {4'b0, 128'ha0fafe1788542cb123a339392a6c7605});
    check("fips_round10", {4'b0, got_rk[10]}, {4'b0, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6});
    for (int r = 0; r < 11; r++) ref_rk[r] = got_rk[r];

    // Same key with stalls, start pulses and key changes mid-sequence (started in the done cycle).
    ready_full = 1'b0;
    clear_got();
    issue_start(FIPS_KEY, 1'b0);
    wait_idle(1'b1, -1);
    for (int r = 0; r < 11; r++) check("stall_same_seq", {4'b0, got_rk[r]}, {4'b0, ref_rk[r]});

    // Abort at round 4, then a fresh key (abort together with start in idle must not block it).
    issue_start(FIPS_KEY, 1'b0);
    wait_idle(1'b0, 4);
    tick();
    clear_got();
    issue_start(SEQ_KEY, 1'b1);
    wait_idle(1'b1, -1);
    check("seq_round10", {4'b0, got_rk[10]}, {4'b0, 128'h13111d7fe3944a17f307a78b4d2b30c5});

    // Random keys back-to-back, with noise.
    for (int i = 0; i < 5; i++) begin
      issue_start(rand128(), 1'($urandom_range(0, 1)));
      wait_idle(1'b1, (i == 2) ? int'($urandom_range(0, 10)) : -1);
      repeat ($urandom_range(0, 2)) tick();
    end

    // Asynchronous reset at round 7, between edges.
    issue_start(rand128(), 1'b0);
    n = 0;
    while (!(rk_valid && rk_round == 4'd7) && n < 200) begin
      tick();
      n++;
    end
    check("reach_round7", {128'b0, rk_round}, 132'd7);
    #3 rst = 1'b1;
    exp_q.delete();
    #1;
    check_outputs_zero("async_rst");
    @(posedge clk);
    #3 rst = 1'b0;
    repeat (4) tick();
    check_outputs_zero("post_rst_idle");

    // Block is usable again after reset.
    issue_start(rand128(), 1'b0);
    wait_idle(1'b1, -1);
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
